// File: rtl/pll_lock_supervisor_if.sv
// PLL LOCK consumer interface: the raw lock/clear inputs going into the
// supervisor, and the reset/status outputs coming back from it.
interface pll_lock_supervisor_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 locked_in;
  logic                 clear_stats;
  logic                 rst_out_n;
  logic                 ready;
  logic                 lock_lost_sticky;
  logic [CNT_WIDTH-1:0] loss_count;
  logic [1:0]           state;

  // Side that drives the PLL lock and clear request and observes status
  modport master (
    output locked_in,
    output clear_stats,
    input  rst_out_n,
    input  ready,
    input  lock_lost_sticky,
    input  loss_count,
    input  state
  );

  // Supervisor side
  modport slave (
    input  locked_in,
    input  clear_stats,
    output rst_out_n,
    output ready,
    output lock_lost_sticky,
    output loss_count,
    output state
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes the raw PLL LOCK, holds downstream DDS
// logic in reset until lock has been stable, re-asserts reset on a filtered
// lock loss with a minimum hold time, and keeps lock-loss statistics.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOSS_FILTER   = 4,
  parameter int HOLD_CYCLES   = 64,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  pll_lock_supervisor_if.slave lock_if
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_e;

  // Counter widths; a parameter of 1 still needs a 1-bit counter
  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int FLT_W  = (LOSS_FILTER   > 1) ? $clog2(LOSS_FILTER)   : 1;
  localparam int HOLD_W = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;

  // Terminal values; each counter is compared against these before it
  // increments, so it never wraps
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(LOSS_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_sync;

  state_e                 state_q;
  logic [STAB_W-1:0]      stab_cnt_q;
  logic [FLT_W-1:0]       flt_cnt_q;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic                   rst_out_n_q;
  logic                   ready_q;

  logic [CNT_WIDTH-1:0]   loss_count_q;
  logic [CNT_WIDTH-1:0]   loss_count_d;
  logic                   sticky_q;
  logic                   sticky_d;
  logic                   loss_evt;

  assign locked_sync = sync_q[SYNC_STAGES-1];

  // A counted loss: the low sample in RUN that completes the filter window
  assign loss_evt = (state_q == RUN) && !locked_sync && (flt_cnt_q == FLT_LAST);

  // Synchronizer chain bringing the asynchronous PLL LOCK into clock_in
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_if.locked_in};
    end
  end

  // Lock FSM with its counters; rst_out_n/ready are registered from next state
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      stab_cnt_q  <= '0;
      flt_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rst_out_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_sync) begin
            state_q    <= STABILIZE;
            stab_cnt_q <= '0;
          end
        end
        STABILIZE: begin
          if (!locked_sync) begin
            // Chatter before release restarts acquisition; not a loss
            state_q <= WAIT_LOCK;
          end else if (stab_cnt_q == STAB_LAST) begin
            state_q     <= RUN;
            flt_cnt_q   <= '0;
            rst_out_n_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            stab_cnt_q <= stab_cnt_q + STAB_W'(1);
          end
        end
        RUN: begin
          if (locked_sync) begin
            flt_cnt_q <= '0;
          end else if (flt_cnt_q == FLT_LAST) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            flt_cnt_q   <= '0;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
          end else begin
            flt_cnt_q <= flt_cnt_q + FLT_W'(1);
          end
        end
        HOLD: begin
          // Minimum reset time after a loss, independent of lock state
          if (hold_cnt_q == HOLD_LAST) begin
            state_q <= WAIT_LOCK;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q     <= WAIT_LOCK;
          rst_out_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  // Statistics next state: clear first, so a coincident loss still counts
  always_comb begin
    loss_count_d = loss_count_q;
    sticky_d     = sticky_q;
    if (lock_if.clear_stats) begin
      loss_count_d = '0;
      sticky_d     = 1'b0;
    end
    if (loss_evt) begin
      sticky_d = 1'b1;
      if (loss_count_d != '1) begin
        loss_count_d = loss_count_d + CNT_WIDTH'(1);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      loss_count_q <= '0;
      sticky_q     <= 1'b0;
    end else begin
      loss_count_q <= loss_count_d;
      sticky_q     <= sticky_d;
    end
  end

  assign lock_if.rst_out_n        = rst_out_n_q;
  assign lock_if.ready            = ready_q;
  assign lock_if.lock_lost_sticky = sticky_q;
  assign lock_if.loss_count       = loss_count_q;
  assign lock_if.state            = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters:
// acquisition latency, glitch filtering, hold time, chatter, statistics
// saturation/clear and asynchronous reset.
module tb_pll_lock_supervisor;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 16;
  localparam int LOSS_FILTER   = 4;
  localparam int HOLD_CYCLES   = 64;
  localparam int CNT_WIDTH     = 2;

  logic clk;
  logic reset_n;

  int vec_cnt     = 0;
  int miscmp_cnt  = 0;
  int ec          = 0;
  bit rst_hi_seen = 1'b0;
  bit rst_lo_seen = 1'b0;

  pll_lock_supervisor_if #(.CNT_WIDTH(CNT_WIDTH)) lock_if ();

  pll_lock_supervisor #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LOSS_FILTER  (LOSS_FILTER),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clock_in(clk),
    .reset_n (reset_n),
    .lock_if (lock_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Edge 0 is the edge just before the current time (we sit 1 ns after it)
  task automatic mark();
    ec = 0;
  endtask

  // Advance to 1 ns after edge n, recording any rst_out_n level seen
  task automatic step_to(input int n);
    while (ec < n) begin
      @(posedge clk);
      #1;
      ec++;
      if (lock_if.rst_out_n === 1'b1) rst_hi_seen = 1'b1;
      if (lock_if.rst_out_n === 1'b0) rst_lo_seen = 1'b1;
    end
  endtask

  // From RUN: 4-cycle lock drop (lock returns at once), HOLD, reacquisition
  task automatic lose(input int exp_cnt, input bit chatter, input bit clr);
    int run_at;
    run_at = chatter ? 98 : 87;
    mark();
    lock_if.locked_in = 1'b0;
    step_to(4);
    lock_if.locked_in = 1'b1;
    step_to(5);
    check_val("loss_pre_state", lock_if.state, 2);
    check_val("loss_pre_rst", lock_if.rst_out_n, 1);
    if (clr) lock_if.clear_stats = 1'b1;
    step_to(6);
    lock_if.clear_stats = 1'b0;
    check_val("loss_state", lock_if.state, 3);
    check_val("loss_rst", lock_if.rst_out_n, 0);
    check_val("loss_ready", lock_if.ready, 0);
    check_val("loss_count", lock_if.loss_count, exp_cnt);
    check_val("loss_sticky", lock_if.lock_lost_sticky, 1);
    rst_hi_seen = 1'b0;
    step_to(69);
    check_val("hold_last_state", lock_if.state, 3);
    step_to(70);
    check_val("hold_exit_state", lock_if.state, 0);
    if (chatter) begin
      step_to(78);
      lock_if.locked_in = 1'b0;
      step_to(79);
      lock_if.locked_in = 1'b1;
      step_to(80);
      check_val("chatter_pre_state", lock_if.state, 1);
      step_to(81);
      check_val("chatter_drop_state", lock_if.state, 0);
      step_to(82);
      check_val("chatter_restab_state", lock_if.state, 1);
    end
    step_to(run_at - 1);
    check_val("reacq_pre_state", lock_if.state, 1);
    check_val("reacq_pre_rst", lock_if.rst_out_n, 0);
    check_val("reacq_no_early_rise", rst_hi_seen, 0);
    step_to(run_at);
    check_val("reacq_state", lock_if.state, 2);
    check_val("reacq_rst", lock_if.rst_out_n, 1);
    check_val("reacq_ready", lock_if.ready, 1);
    check_val("reacq_count", lock_if.loss_count, exp_cnt);
    check_val("reacq_sticky", lock_if.lock_lost_sticky, 1);
  endtask

  initial begin
    reset_n             = 1'b0;
    lock_if.locked_in   = 1'b0;
    lock_if.clear_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_state", lock_if.state, 0);
    check_val("rst_rst_out", lock_if.rst_out_n, 0);
    check_val("rst_ready", lock_if.ready, 0);
    check_val("rst_count", lock_if.loss_count, 0);
    check_val("rst_sticky", lock_if.lock_lost_sticky, 0);

    // Clean acquisition
    reset_n           = 1'b1;
    lock_if.locked_in = 1'b1;
    mark();
    step_to(2);
    check_val("acq_e2_state", lock_if.state, 0);
    step_to(3);
    check_val("acq_e3_state", lock_if.state, 1);
    check_val("acq_e3_rst", lock_if.rst_out_n, 0);
    rst_hi_seen = 1'b0;
    step_to(18);
    check_val("acq_e18_state", lock_if.state, 1);
    check_val("acq_no_early_rise", rst_hi_seen, 0);
    step_to(19);
    check_val("acq_e19_state", lock_if.state, 2);
    check_val("acq_e19_rst", lock_if.rst_out_n, 1);
    check_val("acq_e19_ready", lock_if.ready, 1);

    // 3-cycle glitch in RUN is filtered
    mark();
    lock_if.locked_in = 1'b0;
    rst_lo_seen       = 1'b0;
    step_to(3);
    lock_if.locked_in = 1'b1;
    step_to(5);
    check_val("glitch_e5_state", lock_if.state, 2);
    step_to(12);
    check_val("glitch_no_fall", rst_lo_seen, 0);
    check_val("glitch_state", lock_if.state, 2);
    check_val("glitch_count", lock_if.loss_count, 0);
    check_val("glitch_sticky", lock_if.lock_lost_sticky, 0);

    // Counted losses: hold time, chatter in STABILIZE, saturation at 3
    lose(1, 1'b0, 1'b0);
    lose(2, 1'b1, 1'b0);
    lose(3, 1'b0, 1'b0);
    lose(3, 1'b0, 1'b0);
    lose(3, 1'b0, 1'b0);
    // Clear coincident with the 6th loss: loss wins
    lose(1, 1'b0, 1'b1);

    // Clear alone in RUN
    mark();
    lock_if.clear_stats = 1'b1;
    step_to(1);
    lock_if.clear_stats = 1'b0;
    check_val("clr_count", lock_if.loss_count, 0);
    check_val("clr_sticky", lock_if.lock_lost_sticky, 0);
    check_val("clr_state", lock_if.state, 2);
    check_val("clr_rst", lock_if.rst_out_n, 1);

    // Give the stats something to lose, then reset asynchronously mid-RUN
    lose(1, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("arst_state", lock_if.state, 0);
    check_val("arst_rst_out", lock_if.rst_out_n, 0);
    check_val("arst_ready", lock_if.ready, 0);
    check_val("arst_count", lock_if.loss_count, 0);
    check_val("arst_sticky", lock_if.lock_lost_sticky, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mark();
    step_to(2);
    check_val("reacq_arst_e2_state", lock_if.state, 0);
    step_to(3);
    check_val("reacq_arst_e3_state", lock_if.state, 1);
    rst_hi_seen = 1'b0;
    step_to(18);
    check_val("reacq_arst_no_early_rise", rst_hi_seen, 0);
    step_to(19);
    check_val("reacq_arst_state", lock_if.state, 2);
    check_val("reacq_arst_rst", lock_if.rst_out_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
